// File: rtl/enc_sample_ctrl.sv
// enc_sample_ctrl: periodic sample sequencer for a bank of encoder counters.
// A window timer triggers a one-cycle capture of all live counts into shadow
// registers, followed by a one-cycle clear pulse to the counter datapaths.
// The host reads bias-corrected deltas from the shadows. Per-channel fresh
// flags track which samples are unread, and a sticky overrun flag records
// any capture that overwrote an unread sample.
module enc_sample_ctrl #(
  parameter int          NUM_CH = 4,
  parameter int          CNT_W  = 32,
  parameter int unsigned PERIOD = 500_000,
  parameter int unsigned BIAS   = 100_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH*CNT_W-1:0] count_in,
  output logic                    cnt_latch,
  output logic                    cnt_clr,
  input  logic                    rd_req,
  input  logic [7:0]              rd_ch,
  output logic                    rd_valid,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    rd_err,
  output logic [NUM_CH-1:0]       fresh,
  output logic                    overrun,
  input  logic                    clr_ovr,
  output logic [15:0]             sample_seq
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_CLEAR   = 2'd3;

  localparam logic [31:0]      TIMER_LAST = 32'(PERIOD - 1);
  localparam logic [31:0]      NUM_CH_V   = 32'(NUM_CH);
  localparam logic [CNT_W-1:0] BIAS_V     = CNT_W'(BIAS);

  logic [1:0]        state;
  logic [31:0]       timer;
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] fresh_nxt;
  logic [CNT_W-1:0]  sel_shadow;
  logic [31:0]       rd_ch_ext;
  logic              rd_in_range;
  logic              capture;

  assign capture     = (state == ST_CAPTURE);
  assign cnt_latch   = capture;
  assign cnt_clr     = (state == ST_CLEAR);
  assign rd_ch_ext   = {24'd0, rd_ch};
  assign rd_in_range = (rd_ch_ext < NUM_CH_V);

  // Window sequencer: IDLE waits for enable, RUN counts the window, CAPTURE
  // and CLEAR each last one cycle and always run to completion.
  // NOTE: state is written with non-blocking assignments so every register
  // in the design updates from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == TIMER_LAST) begin
            state <= ST_CAPTURE;
            timer <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_CAPTURE: state <= ST_CLEAR;
        ST_CLEAR:   state <= enable ? ST_RUN : ST_IDLE;
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Shadow registers snapshot every channel and bump the sequence number on capture.
  // NOTE: the shadow array is small and its reset value (BIAS, i.e. a zero
  // delta) is architecturally visible, so it is reset like ordinary flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= BIAS_V;
      sample_seq <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= count_in[k*CNT_W +: CNT_W];
      sample_seq <= sample_seq + 16'd1;
    end
  end

  // Read mux: select the shadow addressed by rd_ch (zero when out of range).
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sel_shadow = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch_ext == 32'(k)) sel_shadow = shadow[k];
    end
  end

  // Fresh-flag next value: a valid read clears its bit, a capture sets all bits and wins.
  always_comb begin
    fresh_nxt = fresh;
    if (rd_req && rd_in_range) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rd_ch_ext == 32'(k)) fresh_nxt[k] = 1'b0;
      end
    end
    if (capture) fresh_nxt = '1;
  end

  // Fresh flags and sticky overrun; a capture over unread data beats clr_ovr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fresh   <= '0;
      overrun <= 1'b0;
    end else begin
      fresh <= fresh_nxt;
      if (capture && (|fresh)) overrun <= 1'b1;
      else if (clr_ovr)        overrun <= 1'b0;
    end
  end

  // Read response: one cycle after rd_req; data and error hold between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (rd_in_range) begin
          rd_data <= sel_shadow - BIAS_V;
          rd_err  <= 1'b0;
        end else begin
          rd_data <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_sample_ctrl.sv
// Testbench for enc_sample_ctrl: randomized reads and counts against a
// window-schedule reference model, with a scoreboard queue for read responses.
module tb_enc_sample_ctrl;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int          P      = 8;
  localparam int unsigned BIAS   = 100_000;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    enable = 1'b0;
  logic [NUM_CH*CNT_W-1:0] count_in = '0;
  logic                    cnt_latch;
  logic                    cnt_clr;
  logic                    rd_req = 1'b0;
  logic [7:0]              rd_ch = '0;
  logic                    rd_valid;
  logic [CNT_W-1:0]        rd_data;
  logic                    rd_err;
  logic [NUM_CH-1:0]       fresh;
  logic                    overrun;
  logic                    clr_ovr = 1'b0;
  logic [15:0]             sample_seq;

  enc_sample_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(P), .BIAS(BIAS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .count_in(count_in),
    .cnt_latch(cnt_latch), .cnt_clr(cnt_clr), .rd_req(rd_req), .rd_ch(rd_ch),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .fresh(fresh),
    .overrun(overrun), .clr_ovr(clr_ovr), .sample_seq(sample_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  rd_exp_t     q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          c = 0;         // clock edges since the current enabled run began
  int          mode = 0;      // 0 random reads, 1 read-all-after-capture, 2 quiet
  bit          directed = 1'b0;
  bit          last_latch = 1'b0;

  // reference model state
  logic [31:0] shadow_m [NUM_CH];
  logic [3:0]  fresh_m;
  logic        ovr_m;
  logic [15:0] seq_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, c, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) shadow_m[k] = BIAS;
    fresh_m = '0;
    ovr_m   = 1'b0;
    seq_m   = '0;
    q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_cnt_latch", {31'd0, cnt_latch}, 32'd0);
    check("rst_cnt_clr",   {31'd0, cnt_clr},   32'd0);
    check("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
    check("rst_rd_data",   rd_data,            32'd0);
    check("rst_rd_err",    {31'd0, rd_err},    32'd0);
    check("rst_fresh",     {28'd0, fresh},     32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    check("rst_seq",       {16'd0, sample_seq}, 32'd0);
  endtask

  // One clock cycle: compare outputs with the model, then drive this cycle's
  // stimulus and advance the model to what the next edge should produce.
  task automatic step();
    logic [3:0] fresh_before;
    logic       latch_now, clr_now;
    int         pos;
    @(posedge clk);
    c++;
    #1;
    latch_now = (c >= P + 1) && ((c - (P + 1)) % (P + 2) == 0);
    clr_now   = (c >= P + 2) && ((c - (P + 2)) % (P + 2) == 0);
    pos       = (c >= P + 1) ? (c - (P + 1)) % (P + 2) : -1;
    check("cnt_latch", {31'd0, cnt_latch}, {31'd0, latch_now});
    check("cnt_clr",   {31'd0, cnt_clr},   {31'd0, clr_now});
    check("fresh",     {28'd0, fresh},     {28'd0, fresh_m});
    check("overrun",   {31'd0, overrun},   {31'd0, ovr_m});
    check("sample_seq", {16'd0, sample_seq}, {16'd0, seq_m});

    for (int k = 0; k < NUM_CH; k++)
      count_in[k*CNT_W +: CNT_W] = BIAS + $urandom_range(0, 600) - 300;
    rd_req  = 1'b0;
    rd_ch   = '0;
    clr_ovr = 1'b0;
    case (mode)
      0: begin
        if (latch_now) begin
          rd_req = 1'b1;
          rd_ch  = 8'($urandom_range(0, NUM_CH - 1));
        end else if ($urandom_range(0, 9) < 3) begin
          rd_req = 1'b1;
          rd_ch  = 8'($urandom_range(0, 4));
          if (rd_ch == 8'd4) rd_ch = 8'($urandom_range(4, 255));
        end
        clr_ovr = ($urandom_range(0, 19) == 0);
        if (directed && c == P + 1) begin
          count_in[2*CNT_W +: CNT_W] = 32'd100_250;
          count_in[0 +: CNT_W]       = 32'd99_990;
        end
        if (directed && c == P + 2) begin rd_req = 1'b1; rd_ch = 8'd2; end
        if (directed && c == P + 3) begin rd_req = 1'b1; rd_ch = 8'd0; end
        if (directed && c == P + 4) begin rd_req = 1'b1; rd_ch = 8'd7; end
      end
      1: begin
        if (pos >= 2 && pos <= 5) begin
          rd_req = 1'b1;
          rd_ch  = 8'(pos - 2);
        end
        clr_ovr = (pos == 6);
      end
      default: ;
    endcase

    fresh_before = fresh_m;
    if (rd_req) begin
      if (rd_ch < NUM_CH) begin
        q.push_back('{c + 1, shadow_m[rd_ch] - BIAS, 1'b0});
        fresh_m[rd_ch] = 1'b0;
      end else begin
        q.push_back('{c + 1, 32'd0, 1'b1});
      end
    end
    if (latch_now) begin
      if (|fresh_before) ovr_m = 1'b1;
      else if (clr_ovr)  ovr_m = 1'b0;
      for (int k = 0; k < NUM_CH; k++) shadow_m[k] = count_in[k*CNT_W +: CNT_W];
      fresh_m = '1;
      seq_m   = seq_m + 16'd1;
    end else if (clr_ovr) begin
      ovr_m = 1'b0;
    end
    last_latch = latch_now;
  endtask

  // Monitor: pops the scoreboard whenever a read response appears and checks
  // that rd_data/rd_err hold between responses.
  initial begin
    rd_exp_t     e;
    logic [31:0] last_data;
    logic        last_err;
    last_data = '0;
    last_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_data = '0;
        last_err  = 1'b0;
      end else if (rd_valid) begin
        if (q.size() == 0) begin
          check("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          check("rd_latency", c, e.cyc);
          check("rd_data", rd_data, e.data);
          check("rd_err", {31'd0, rd_err}, {31'd0, e.err});
          last_data = e.data;
          last_err  = e.err;
        end
      end else begin
        check("rd_hold_data", rd_data, last_data);
        check("rd_hold_err", {31'd0, rd_err}, {31'd0, last_err});
        if (q.size() > 0 && q[0].cyc <= c) begin
          check("rd_valid_missing", {31'd0, rd_valid}, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // Random run from reset with directed captures/reads in the first window.
    @(negedge clk);
    enable = 1'b1;
    reset  = 1'b0;
    c      = 0;
    mode   = 0;
    directed = 1'b1;
    repeat (6 * (P + 2)) step();
    directed = 1'b0;

    // Drain all channels after each capture: overrun clears and stays clear.
    mode = 1;
    repeat (4 * (P + 2)) step();

    // enable dropped during CAPTURE: CLEAR still pulses, then the block idles.
    mode = 0;
    do step(); while (!last_latch);
    enable = 1'b0;
    @(posedge clk);
    c++;
    #1;
    check("drop_cnt_clr",   {31'd0, cnt_clr},   32'd1);
    check("drop_cnt_latch", {31'd0, cnt_latch}, 32'd0);
    check("drop_seq",       {16'd0, sample_seq}, {16'd0, seq_m});
    rd_req  = 1'b0;
    clr_ovr = 1'b0;
    for (int i = 0; i < 2 * (P + 2); i++) begin
      @(posedge clk);
      c++;
      #1;
      check("idle_cnt_latch", {31'd0, cnt_latch}, 32'd0);
      check("idle_cnt_clr",   {31'd0, cnt_clr},   32'd0);
      check("idle_fresh",     {28'd0, fresh},     {28'd0, fresh_m});
      check("idle_overrun",   {31'd0, overrun},   {31'd0, ovr_m});
    end

    // Re-enable from IDLE: schedule restarts, then reset lands mid-RUN.
    enable = 1'b1;
    c      = 0;
    repeat (2 * (P + 2)) step();
    mode = 2;
    do step(); while (((c - (P + 1)) % (P + 2)) != 5);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    check("rd_queue_drained", q.size(), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_cnt_clr",   {31'd0, cnt_clr},   32'd0);
      check("rst_hold_cnt_latch", {31'd0, cnt_latch}, 32'd0);
    end
    model_reset();

    // Restart after reset: shadows read back as zero delta until first capture.
    @(negedge clk);
    reset = 1'b0;
    c     = 0;
    mode  = 0;
    repeat (3 * (P + 2)) step();
    mode = 2;
    repeat (3) step();
    check("final_queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
